fetch_redirect_unit: RTL and testbench
======================================

# fetch_redirect_unit

Instruction-fetch stage with branch/jump resolution for the MIPS core. It owns the PC, fetches words from instruction memory over a req/ready handshake, and presents one instruction at a time to decode under valid/ack backpressure. It consumes the branch and jump strobes the control decoder produces (beq, bne, BGEZ, BLEZ, BGTZ, BLTZ, J, JAL, JR, JALR), evaluates the condition and target, redirects fetch, and emits the link write for JAL/JALR. There are no delay slots: a taken redirect squashes any fetched-but-unconsumed instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  Single clock. All state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- imem_req  out  1  Fetch request.
- imem_addr  out  32  Fetch word address. Bits [1:0] are always 0.
- imem_ready  in  1  Memory returns `imem_rdata` this cycle.
- imem_rdata  in  32  Fetched word.
- if_valid  out  1  `if_instr` and `if_pc` are valid.
- if_ack  in  1  Decode accepts the presented instruction.
- if_instr  out  32  Fetched instruction.
- if_pc  out  32  Address of `if_instr`.
- res_valid  in  1  Qualifies the branch and jump inputs for this cycle.
- beq, bne, bgez, blez, bgtz, bltz, j, jal, jr, jalr  in  1 each  Decoded strobes for the resolving instruction. At most one is high.
- br_pc  in  32  PC of the resolving instruction.
- rs_val, rt_val  in  32  Register operands.
- imm16  in  16  Branch offset.
- target26  in  26  J/JAL index.
- rd  in  5  JALR destination.
- link_valid  out  1  One-cycle pulse: write `link_addr` to `link_reg`.
- link_addr  out  32  Return address.
- link_reg  out  5  Link destination register.
- fault  out  1  Sticky misaligned-target fault.

## Operation
- Conditions compare rs_val as a signed value: beq rs==rt; bne rs!=rt; bgez rs>=0; bgtz rs>0; blez rs<=0; bltz rs<0. j, jal, jr and jalr are always taken.
- taken = res_valid & (condition true or any jump strobe).
- Branch target = br_pc + 4 + (sign-extended imm16 << 2), 32-bit wrap.
- J/JAL target = {(br_pc+4)[31:28], target26, 2'b00}.
- JR/JALR target = rs_val.
- Misaligned target is only possible for JR/JALR (rs_val[1:0] != 0). It sets `fault` and is not a redirect.
- Link: jal → link_reg=31; jalr → link_reg=rd. link_addr = br_pc + 4.
- FSM states: BOOT, REQ, HOLD, DROP, FAULT.
  - BOOT → REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready: latch if_instr and if_pc, set pc += 4, go to HOLD.
  - HOLD: if_valid=1. On if_ack, go to REQ.
  - DROP: an outstanding request is being discarded. imem_req=1 with the old address until imem_ready, then go to REQ, or to FAULT if a fault is pending. The returned data is discarded.
  - FAULT: imem_req=0, if_valid=0. Only rst exits this state.
- Handshake rule: once imem_req is raised, imem_req and imem_addr stay constant until imem_ready.
- Taken redirect (priority over if_ack and imem_ready):
  - pc ← target and if_valid ← 0.
  - From REQ with imem_ready high: discard the data and go to REQ.
  - From REQ without imem_ready: go to DROP.
  - From HOLD or BOOT: go to REQ.
  - From DROP: update pc (the latest redirect wins) and stay in DROP.
- Fault detection: sets fault_pending. With a request outstanding (REQ without ready, or DROP), go to DROP and then FAULT. Otherwise go straight to FAULT.

## Timing
- Reset values: pc=RESET_PC, state BOOT, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, link_valid=0, link_addr=0, link_reg=0, fault=0.
- Reset asserted mid-request abandons the request immediately. Memory must also be reset.
- First imem_req is asserted in the first cycle after rst deasserts.
- Latency:
  - Ready in cycle N → if_valid in N+1.
  - if_ack in cycle M → imem_req in M+1.
  - Best-case throughput is 1 instruction per 2 cycles.
- Redirect in cycle N → if_valid=0 and imem_addr=target in N+1, unless the state is DROP.
- link_valid pulses in the cycle after a taken jal or jalr and is registered. It asserts even if fetch enters DROP.
- fault is registered: it rises the cycle after detection and holds until rst.
- res_valid with no strobe high, or with a branch not taken: no effect.

## Test plan
- Reset with RESET_PC=0x100, imem_ready=1 every cycle, if_ack=1 → imem_addr sequence 0x100, 0x104, 0x108; if_pc matches each; if_valid never high during reset.
- Branch beq at br_pc=0x200 with rs=rt=5 and imm16=0xFFFF → target 0x200. bne with the same operands → no redirect.
- Branch bgez with rs=0x8000_0000 → not taken. bltz with the same rs → taken. blez with rs=0 → taken. bgtz with rs=0 → not taken.
- Redirect collision: redirect while in REQ with imem_ready=0 → DROP; imem_addr holds the old address until ready; the returned data never appears on if_instr; the next request goes to the target. A second redirect while in DROP → the last target is fetched.
- Link write: jal at br_pc=0x3000_0010 with target26=0x000_0040 → fetch 0x3000_0100; link_valid=1 for one cycle with link_reg=31 and link_addr=0x3000_0014. jalr with rd=5 → link_reg=5.
- Fault: jr with rs_val=0x1002 → fault=1 the next cycle; imem_req=0 and if_valid=0 indefinitely; rst clears fault and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// Instruction fetch stage with branch/jump resolution for the MIPS core.
// Owns the PC, fetches over a req/ready handshake, hands one instruction
// at a time to decode under valid/ack, and redirects fetch on taken
// branches/jumps. No delay slots: a redirect squashes the held instruction.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ack,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        res_valid,
  input  logic        beq,
  input  logic        bne,
  input  logic        bgez,
  input  logic        blez,
  input  logic        bgtz,
  input  logic        bltz,
  input  logic        j,
  input  logic        jal,
  input  logic        jr,
  input  logic        jalr,
  input  logic [31:0] br_pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [4:0]  rd,
  output logic        link_valid,
  output logic [31:0] link_addr,
  output logic [4:0]  link_reg,
  output logic        fault
);

  typedef enum logic [2:0] {BOOT, REQ, HOLD, DROP, FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic        fault_pending, fault_pending_nxt;
  logic        latch_fetch;

  logic        rs_neg, rs_zero;
  logic        cond_true, is_jump, is_reg_jump;
  logic        taken, misaligned, active;
  logic        redirect, fault_det, link_fire;
  logic [31:0] pc_plus4, br_offset, br_target, j_target, target;

  // Branch condition, target selection and redirect/fault qualification
  always_comb begin
    rs_neg      = rs_val[31];
    rs_zero     = (rs_val == 32'd0);
    cond_true   = (beq  & (rs_val == rt_val)) |
                  (bne  & (rs_val != rt_val)) |
                  (bgez & ~rs_neg) |
                  (bgtz & ~rs_neg & ~rs_zero) |
                  (blez & (rs_neg | rs_zero)) |
                  (bltz & rs_neg);
    is_reg_jump = jr | jalr;
    is_jump     = j | jal | is_reg_jump;
    taken       = res_valid & (cond_true | is_jump);
    pc_plus4    = br_pc + 32'd4;
    br_offset   = {{14{imm16[15]}}, imm16, 2'b00};
    br_target   = pc_plus4 + br_offset;
    j_target    = {pc_plus4[31:28], target26, 2'b00};
    if (is_reg_jump)
      target = rs_val;
    else if (j | jal)
      target = j_target;
    else
      target = br_target;
    misaligned  = res_valid & is_reg_jump & (rs_val[1:0] != 2'b00);
    active      = (state != FAULT);
    redirect    = active & taken & ~misaligned;
    fault_det   = active & misaligned;
    link_fire   = active & res_valid & (jal | (jalr & ~misaligned));
  end

  // Fetch FSM next-state: redirects outrank ack/ready, faults park the stage
  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    drop_addr_nxt     = drop_addr;
    fault_pending_nxt = fault_pending;
    latch_fetch       = 1'b0;
    case (state)
      BOOT: begin
        if (fault_det) begin
          fault_pending_nxt = 1'b1;
          state_nxt         = FAULT;
        end else begin
          if (redirect) pc_nxt = target;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (fault_det) begin
          fault_pending_nxt = 1'b1;
          if (imem_ready) begin
            state_nxt = FAULT;
          end else begin
            drop_addr_nxt = pc;
            state_nxt     = DROP;
          end
        end else if (redirect) begin
          pc_nxt = target;
          if (!imem_ready) begin
            drop_addr_nxt = pc;
            state_nxt     = DROP;
          end
        end else if (imem_ready) begin
          latch_fetch = 1'b1;
          pc_nxt      = pc + 32'd4;
          state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (fault_det) begin
          fault_pending_nxt = 1'b1;
          state_nxt         = FAULT;
        end else if (redirect) begin
          pc_nxt    = target;
          state_nxt = REQ;
        end else if (if_ack) begin
          state_nxt = REQ;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_nxt = target;
        end else begin
          if (fault_det) fault_pending_nxt = 1'b1;
          if (imem_ready)
            state_nxt = (fault_det | fault_pending) ? FAULT : REQ;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC and discard-address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      drop_addr     <= RESET_PC;
      fault_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      drop_addr     <= drop_addr_nxt;
      fault_pending <= fault_pending_nxt;
    end
  end

  // Capture the fetched word and its address when a request completes
  always_ff @(posedge clk) begin
    if (rst) begin
      if_instr <= 32'd0;
      if_pc    <= 32'd0;
    end else if (latch_fetch) begin
      if_instr <= imem_rdata;
      if_pc    <= pc;
    end
  end

  // Registered link-write pulse for jal/jalr
  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid <= 1'b0;
      link_addr  <= 32'd0;
      link_reg   <= 5'd0;
    end else begin
      link_valid <= link_fire;
      if (link_fire) begin
        link_addr <= pc_plus4;
        link_reg  <= jal ? 5'd31 : rd;
      end
    end
  end

  assign imem_req  = (state == REQ) || (state == DROP);
  assign imem_addr = (state == DROP) ? drop_addr : pc;
  assign if_valid  = (state == HOLD);
  assign fault     = fault_pending;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed scenarios plus a
// randomized run checked against a transaction-level fetch model.
module tb_fetch_redirect_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ack;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        res_valid;
  logic        beq, bne, bgez, blez, bgtz, bltz, j, jal, jr, jalr;
  logic [31:0] br_pc, rs_val, rt_val;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [4:0]  rd;
  logic        link_valid;
  logic [31:0] link_addr;
  logic [4:0]  link_reg;
  logic        fault;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  fetch_redirect_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ack(if_ack), .if_instr(if_instr), .if_pc(if_pc),
    .res_valid(res_valid),
    .beq(beq), .bne(bne), .bgez(bgez), .blez(blez), .bgtz(bgtz), .bltz(bltz),
    .j(j), .jal(jal), .jr(jr), .jalr(jalr),
    .br_pc(br_pc), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
    .target26(target26), .rd(rd),
    .link_valid(link_valid), .link_addr(link_addr), .link_reg(link_reg),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: odd multiplier keeps every word address distinct
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = memfn(imem_addr);

  // kind: 0 beq 1 bne 2 bgez 3 blez 4 bgtz 5 bltz 6 j 7 jal 8 jr 9 jalr 10 none
  function automatic logic ref_taken(input int kind, input logic [31:0] rs, input logic [31:0] rt);
    case (kind)
      0: return rs == rt;
      1: return rs != rt;
      2: return $signed(rs) >= 0;
      3: return $signed(rs) <= 0;
      4: return $signed(rs) > 0;
      5: return $signed(rs) < 0;
      6, 7, 8, 9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input int kind, input logic [31:0] pc,
                                             input logic [31:0] rs, input logic [15:0] imm,
                                             input logic [25:0] t26);
    int off;
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    off = int'($signed(imm)) * 4;
    if (kind <= 5) return nxt + 32'(off);
    if (kind == 6 || kind == 7) return (nxt & 32'hF000_0000) | (32'(t26) * 32'd4);
    return rs;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_res();
    res_valid = 0;
    {beq, bne, bgez, blez, bgtz, bltz, j, jal, jr, jalr} = '0;
  endtask

  task automatic drive_res(input int kind, input logic rv, input logic [31:0] pc,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [15:0] imm, input logic [25:0] t26, input logic [4:0] rdv);
    clear_res();
    res_valid = rv;
    br_pc = pc; rs_val = rs; rt_val = rt; imm16 = imm; target26 = t26; rd = rdv;
    case (kind)
      0: beq = 1;  1: bne = 1;  2: bgez = 1; 3: blez = 1; 4: bgtz = 1;
      5: bltz = 1; 6: j = 1;    7: jal = 1;  8: jr = 1;   9: jalr = 1;
      default: ;
    endcase
  endtask

  // Let the pending fetch complete so the stage is holding an instruction
  task automatic go_hold();
    imem_ready = 1; if_ack = 0;
    for (int i = 0; i < 20; i++) begin
      if (if_valid) break;
      tick();
    end
    imem_ready = 0;
    total++;
    if (if_valid !== 1'b1) $display("[TB] FAIL go_hold timeout if_valid=%b need 1", if_valid);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1; imem_ready = 0; if_ack = 0; clear_res();
    br_pc = 0; rs_val = 0; rt_val = 0; imm16 = 0; target26 = 0; rd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({imem_req, if_valid, fault, link_valid} !== 4'b0000 || imem_addr !== RST_PC ||
          if_instr !== 32'd0 || if_pc !== 32'd0 || link_addr !== 32'd0 || link_reg !== 5'd0)
        $display("[TB] FAIL reset_values req=%b valid=%b fault=%b link=%b addr=%h instr=%h pc=%h need 0/0/0/0 addr=%h",
                 imem_req, if_valid, fault, link_valid, imem_addr, if_instr, if_pc, RST_PC);
      else passed++;
    end
    rst = 0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC)
      $display("[TB] FAIL first_req req=%b addr=%h need 1 %h", imem_req, imem_addr, RST_PC);
    else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    imem_ready = 1; if_ack = 1;
    for (int k = 0; k < 3; k++) begin
      a = RST_PC + 32'(4 * k);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== a || if_valid !== 1'b0)
        $display("[TB] FAIL seq_req%0d req=%b addr=%h need 1 %h", k, imem_req, imem_addr, a);
      else passed++;
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== a || if_instr !== memfn(a) || imem_req !== 1'b0)
        $display("[TB] FAIL seq_deliver%0d valid=%b pc=%h instr=%h need 1 %h %h",
                 k, if_valid, if_pc, if_instr, a, memfn(a));
      else passed++;
      tick();
    end
    imem_ready = 0; if_ack = 0;
  endtask

  task automatic test_branches();
    int          kinds [11] = '{0, 1, 2, 5, 3, 4, 1, 4, 6, 0, 10};
    logic        rvs   [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    logic [31:0] pcs   [11] = '{32'h200, 32'h200, 32'h300, 32'h300, 32'h400, 32'h400,
                                32'h1000, 32'h2000, 32'h4000_0000, 32'h600, 32'h700};
    logic [31:0] rss   [11] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
                                32'd1, 32'd7, 32'd0, 32'd3, 32'd0};
    logic [31:0] rts   [11] = '{32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0,
                                32'd2, 32'd0, 32'd0, 32'd3, 32'd0};
    logic [15:0] imms  [11] = '{16'hFFFF, 16'hFFFF, 16'h0020, 16'h0020, 16'hFFF0, 16'h0008,
                                16'h0010, 16'h8000, 16'h0000, 16'h0004, 16'h0004};
    logic [31:0] held, tgt;
    logic        tk;
    for (int e = 0; e < 11; e++) begin
      go_hold();
      held = if_pc;
      tk   = rvs[e] & ref_taken(kinds[e], rss[e], rts[e]);
      tgt  = ref_target(kinds[e], pcs[e], rss[e], imms[e], 26'h123);
      drive_res(kinds[e], rvs[e], pcs[e], rss[e], rts[e], imms[e], 26'h123, 5'd0);
      tick();
      clear_res();
      total++;
      if (tk) begin
        if (imem_req !== 1'b1 || imem_addr !== tgt || if_valid !== 1'b0)
          $display("[TB] FAIL branch%0d_taken req=%b addr=%h valid=%b need 1 %h 0",
                   e, imem_req, imem_addr, if_valid, tgt);
        else passed++;
      end else begin
        if (if_valid !== 1'b1 || if_pc !== held || imem_req !== 1'b0)
          $display("[TB] FAIL branch%0d_not_taken valid=%b pc=%h req=%b need 1 %h 0",
                   e, if_valid, if_pc, imem_req, held);
        else passed++;
      end
    end
    go_hold();
    drive_res(0, 1, 32'h200, 32'd5, 32'd5, 16'hFFFF, 26'd0, 5'd0);
    tick();
    clear_res();
    total++;
    if (imem_addr !== 32'h0000_0200)
      $display("[TB] FAIL beq_self_loop addr=%h need 00000200", imem_addr);
    else passed++;
  endtask

  task automatic test_redirect_collision();
    logic [31:0] a;
    go_hold();
    if_ack = 1;
    tick();
    if_ack = 0; imem_ready = 0;
    a = imem_addr;
    drive_res(0, 1, 32'h800, 32'd1, 32'd1, 16'h0010, 26'd0, 5'd0);
    tick();
    clear_res();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== a || if_valid !== 1'b0)
      $display("[TB] FAIL drop_hold_addr req=%b addr=%h valid=%b need 1 %h 0", imem_req, imem_addr, if_valid, a);
    else passed++;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== a)
      $display("[TB] FAIL drop_stable req=%b addr=%h need 1 %h", imem_req, imem_addr, a);
    else passed++;
    drive_res(6, 1, 32'h900, 32'd0, 32'd0, 16'd0, 26'h300, 5'd0);
    tick();
    clear_res();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== a || if_valid !== 1'b0)
      $display("[TB] FAIL drop_second_redirect addr=%h valid=%b need %h 0", imem_addr, if_valid, a);
    else passed++;
    imem_ready = 1;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0C00 || if_valid !== 1'b0)
      $display("[TB] FAIL drop_exit req=%b addr=%h valid=%b need 1 00000c00 0", imem_req, imem_addr, if_valid);
    else passed++;
    tick();
    imem_ready = 0;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0000_0C00 || if_instr !== memfn(32'h0000_0C00))
      $display("[TB] FAIL drop_last_target valid=%b pc=%h instr=%h need 1 00000c00 %h",
               if_valid, if_pc, if_instr, memfn(32'h0000_0C00));
    else passed++;
  endtask

  task automatic test_link();
    go_hold();
    drive_res(7, 1, 32'h3000_0010, 32'd0, 32'd0, 16'd0, 26'h000_0040, 5'd9);
    tick();
    clear_res();
    total++;
    if (imem_addr !== 32'h3000_0100 || link_valid !== 1'b1 || link_reg !== 5'd31 || link_addr !== 32'h3000_0014)
      $display("[TB] FAIL jal_link addr=%h lv=%b reg=%0d la=%h need 30000100 1 31 30000014",
               imem_addr, link_valid, link_reg, link_addr);
    else passed++;
    tick();
    total++;
    if (link_valid !== 1'b0)
      $display("[TB] FAIL link_pulse_width lv=%b need 0", link_valid);
    else passed++;
    go_hold();
    drive_res(9, 1, 32'h500, 32'h400, 32'd0, 16'd0, 26'd0, 5'd5);
    tick();
    clear_res();
    total++;
    if (imem_addr !== 32'h400 || link_valid !== 1'b1 || link_reg !== 5'd5 || link_addr !== 32'h504)
      $display("[TB] FAIL jalr_link addr=%h lv=%b reg=%0d la=%h need 00000400 1 5 00000504",
               imem_addr, link_valid, link_reg, link_addr);
    else passed++;
  endtask

  // Transaction model: one instruction slot, one outstanding request,
  // and an optional request being thrown away after a redirect.
  task automatic test_random();
    logic [31:0] exp_fetch, disc_addr, slot_pc, lk_addr, tgt, rs, rt, pc;
    logic        discarding, slot_valid, lk_valid, exp_req, tk, rv;
    logic [4:0]  lk_reg, rdv;
    logic [15:0] imm;
    logic [25:0] t26;
    int          kind;
    rst = 1; imem_ready = 0; if_ack = 0; clear_res();
    tick(); tick();
    rst = 0;
    tick();
    exp_fetch = RST_PC; discarding = 0; slot_valid = 0; slot_pc = 0;
    disc_addr = 0; lk_valid = 0; lk_addr = 0; lk_reg = 0;
    for (int c = 0; c < 600; c++) begin
      exp_req = discarding || !slot_valid;
      total++;
      if (imem_req !== exp_req || if_valid !== slot_valid ||
          (exp_req && imem_addr !== (discarding ? disc_addr : exp_fetch)) ||
          (slot_valid && (if_pc !== slot_pc || if_instr !== memfn(slot_pc))) ||
          link_valid !== lk_valid || (lk_valid && (link_addr !== lk_addr || link_reg !== lk_reg)) ||
          fault !== 1'b0)
        $display("[TB] FAIL random_c%0d req=%b addr=%h valid=%b pc=%h lv=%b la=%h lr=%0d need req=%b addr=%h valid=%b pc=%h lv=%b la=%h lr=%0d",
                 c, imem_req, imem_addr, if_valid, if_pc, link_valid, link_addr, link_reg,
                 exp_req, discarding ? disc_addr : exp_fetch, slot_valid, slot_pc, lk_valid, lk_addr, lk_reg);
      else passed++;
      imem_ready = ($urandom_range(0, 1) == 1);
      if_ack     = ($urandom_range(0, 1) == 1);
      tk = 0; lk_valid = 0;
      clear_res();
      if ($urandom_range(0, 4) == 0) begin
        kind = $urandom_range(0, 10);
        rv   = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 4))
          0: rs = 32'd0;
          1: rs = 32'hFFFF_FFFF;
          2: rs = 32'h8000_0000;
          3: rs = 32'd1;
          default: rs = $urandom;
        endcase
        if (kind == 8 || kind == 9) rs = rs & 32'hFFFF_FFFC;
        rt  = ($urandom_range(0, 1) == 1) ? rs : $urandom;
        pc  = $urandom & 32'hFFFF_FFFC;
        imm = 16'($urandom);
        t26 = 26'($urandom);
        rdv = 5'($urandom);
        drive_res(kind, rv, pc, rs, rt, imm, t26, rdv);
        tk  = rv & ref_taken(kind, rs, rt);
        tgt = ref_target(kind, pc, rs, imm, t26);
        if (rv && (kind == 7 || kind == 9)) begin
          lk_valid = 1;
          lk_addr  = pc + 32'd4;
          lk_reg   = (kind == 7) ? 5'd31 : rdv;
        end
      end
      if (tk) begin
        if (!discarding && exp_req && !imem_ready) begin
          discarding = 1;
          disc_addr  = exp_fetch;
        end
        exp_fetch  = tgt;
        slot_valid = 0;
      end else if (exp_req && imem_ready) begin
        if (discarding) discarding = 0;
        else begin
          slot_valid = 1;
          slot_pc    = exp_fetch;
          exp_fetch  = exp_fetch + 32'd4;
        end
      end else if (slot_valid && if_ack) begin
        slot_valid = 0;
      end
      tick();
      clear_res();
    end
    imem_ready = 0; if_ack = 0;
  endtask

  task automatic test_fault();
    go_hold();
    drive_res(8, 1, 32'h40, 32'h0000_1002, 32'd0, 16'd0, 26'd0, 5'd0);
    tick();
    clear_res();
    total++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0)
      $display("[TB] FAIL fault_rise fault=%b req=%b valid=%b need 1 0 0", fault, imem_req, if_valid);
    else passed++;
    imem_ready = 1; if_ack = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) drive_res(6, 1, 32'h0, 32'd0, 32'd0, 16'd0, 26'h10, 5'd0);
      tick();
      clear_res();
      total++;
      if (fault !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0)
        $display("[TB] FAIL fault_sticky%0d fault=%b req=%b valid=%b need 1 0 0", i, fault, imem_req, if_valid);
      else passed++;
    end
    rst = 1; imem_ready = 0; if_ack = 0;
    tick();
    total++;
    if (fault !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RST_PC)
      $display("[TB] FAIL fault_reset fault=%b req=%b addr=%h need 0 0 %h", fault, imem_req, imem_addr, RST_PC);
    else passed++;
    rst = 0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC)
      $display("[TB] FAIL fault_restart req=%b addr=%h need 1 %h", imem_req, imem_addr, RST_PC);
    else passed++;
    drive_res(8, 1, 32'h40, 32'h0000_1002, 32'd0, 16'd0, 26'd0, 5'd0);
    tick();
    clear_res();
    total++;
    if (fault !== 1'b1 || imem_req !== 1'b1 || imem_addr !== RST_PC || if_valid !== 1'b0)
      $display("[TB] FAIL fault_via_drop fault=%b req=%b addr=%h need 1 1 %h", fault, imem_req, imem_addr, RST_PC);
    else passed++;
    imem_ready = 1;
    tick();
    imem_ready = 0;
    total++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0)
      $display("[TB] FAIL fault_after_drop fault=%b req=%b valid=%b need 1 0 0", fault, imem_req, if_valid);
    else passed++;
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branches();
    test_redirect_collision();
    test_link();
    test_random();
    test_fault();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
